// File: rtl/slave_serial_bridge_if.sv
// rtl/slave_serial_bridge_if.sv - serial bus and parallel request signals of the slave bridge
interface slave_serial_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  mode;
  logic                  wr_bus;
  logic                  master_valid;
  logic                  master_ready;
  logic                  rd_bus;
  logic                  slave_ready;
  logic                  slave_valid;
  logic                  split;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport slave (
    input  mode, wr_bus, master_valid, master_ready, req_ready, rsp_valid, rsp_rdata,
    output rd_bus, slave_ready, slave_valid, split, req_valid, req_write, req_addr, req_wdata
  );

  modport master (
    output mode, wr_bus, master_valid, master_ready, req_ready, rsp_valid, rsp_rdata,
    input  rd_bus, slave_ready, slave_valid, split, req_valid, req_write, req_addr, req_wdata
  );
endinterface

// File: rtl/slave_serial_bridge.sv
// rtl/slave_serial_bridge.sv - bit-serial bus slave to parallel request bridge with optional read split
module slave_serial_bridge #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int SPLIT_EN      = 0,
  parameter int SPLIT_TIMEOUT = 4
) (
  input logic                  clk,
  input logic                  rstn,
  slave_serial_bridge_if.slave bus
);
  localparam int CNT_W  = $clog2(ADDR_WIDTH + DATA_WIDTH + 1);
  localparam int WCNT_W = $clog2(SPLIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(ADDR_WIDTH + DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  SEND_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(SPLIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_SPLIT, S_SEND
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [WCNT_W-1:0]     r_wait_cnt;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_mode;

  // mode is only valid on the wire during the first address bit
  assign w_mode = (r_cnt == '0) ? bus.mode : r_mode;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.master_valid) w_next = S_ADDR;
      S_ADDR: begin
        if (!bus.master_valid)    w_next = S_IDLE;
        else if (r_cnt == ADDR_LAST) w_next = w_mode ? S_DATA : S_REQ;
      end
      S_DATA: begin
        if (!bus.master_valid)    w_next = S_IDLE;
        else if (r_cnt == WORD_LAST) w_next = S_REQ;
      end
      S_REQ:   if (bus.req_ready) w_next = r_mode ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // a response arriving on the timeout cycle still wins over the split
        if (bus.rsp_valid) w_next = S_SEND;
        else if ((SPLIT_EN != 0) && (r_wait_cnt == WAIT_LAST)) w_next = S_SPLIT;
      end
      S_SPLIT: if (bus.rsp_valid) w_next = S_SEND;
      S_SEND:  if (bus.master_ready && (r_cnt == SEND_LAST)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wait_cnt <= '0;
      r_mode     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.master_valid) r_wdata <= '0;
        end
        S_ADDR: if (bus.master_valid) begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_addr <= {r_addr[ADDR_WIDTH-2:0], bus.wr_bus};
          if (r_cnt == '0) r_mode <= bus.mode;
        end
        S_DATA: if (bus.master_valid) begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_wdata <= {r_wdata[DATA_WIDTH-2:0], bus.wr_bus};
        end
        S_REQ: r_wait_cnt <= '0;
        S_WAIT: begin
          if (bus.rsp_valid) begin
            r_rdata <= bus.rsp_rdata;
            r_cnt   <= '0;
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        S_SPLIT: if (bus.rsp_valid) begin
          r_rdata <= bus.rsp_rdata;
          r_cnt   <= '0;
        end
        S_SEND: if (bus.master_ready) begin
          r_rdata <= r_rdata << 1;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.slave_ready = (r_state == S_ADDR) || (r_state == S_DATA);
  assign bus.slave_valid = (r_state == S_SEND);
  assign bus.split       = (r_state == S_SPLIT);
  assign bus.req_valid   = (r_state == S_REQ);
  assign bus.rd_bus      = (r_state == S_SEND) && r_rdata[DATA_WIDTH-1];
  assign bus.req_write   = r_mode;
  assign bus.req_addr    = r_addr;
  assign bus.req_wdata   = r_wdata;
endmodule

// File: tb/tb_slave_serial_bridge.sv
// tb/tb_slave_serial_bridge.sv - randomized and directed bench for slave_serial_bridge
module tb_slave_serial_bridge;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk, rstn;
  logic mode, wr_bus, master_valid, master_ready, req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  bit rand_en;

  slave_serial_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  slave_serial_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  assign bus_a.mode = mode;                  assign bus_b.mode = mode;
  assign bus_a.wr_bus = wr_bus;              assign bus_b.wr_bus = wr_bus;
  assign bus_a.master_valid = master_valid;  assign bus_b.master_valid = master_valid;
  assign bus_a.master_ready = master_ready;  assign bus_b.master_ready = master_ready;
  assign bus_a.req_ready = req_ready;        assign bus_b.req_ready = req_ready;
  assign bus_a.rsp_valid = rsp_valid;        assign bus_b.rsp_valid = rsp_valid;
  assign bus_a.rsp_rdata = rsp_rdata;        assign bus_b.rsp_rdata = rsp_rdata;

  slave_serial_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(1), .SPLIT_TIMEOUT(TO))
    dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  slave_serial_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(0), .SPLIT_TIMEOUT(TO))
    dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level model: expected outputs for the current cycle
  logic          exp_sready, exp_svalid, exp_split, exp_rv, exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  bit            m_idle;
  bit            m_bits[$];
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  int            m_split_cycle;

  task automatic m_clear();
    exp_sready = 0; exp_svalid = 0; exp_split = 0; exp_rv = 0; exp_rd = 0;
    exp_wr = 0; exp_addr = '0; exp_wdata = '0; m_idle = 1;
  endtask

  task automatic m_step(output bit rst);
    @(posedge clk or negedge rstn);
    rst = (rstn !== 1'b1);
  endtask

  task automatic m_txn();
    bit rst;
    bit w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int n;
    do begin m_step(rst); if (rst) return; end while (master_valid !== 1'b1);
    m_idle = 0; exp_sready = 1; a = '0; d = '0; w = 0;
    for (int i = 0; i < AW; i++) begin
      m_step(rst); if (rst) return;
      if (master_valid !== 1'b1) return;
      if (i == 0) w = mode;
      a = {a[AW-2:0], wr_bus};
    end
    if (w) begin
      for (int i = 0; i < DW; i++) begin
        m_step(rst); if (rst) return;
        if (master_valid !== 1'b1) return;
        d = {d[DW-2:0], wr_bus};
      end
    end
    exp_sready = 0; exp_rv = 1; exp_wr = w; exp_addr = a; exp_wdata = d;
    do begin m_step(rst); if (rst) return; end while (req_ready !== 1'b1);
    m_last_addr = a; m_last_wdata = d;
    exp_rv = 0;
    if (w) return;
    n = 0;
    forever begin
      m_step(rst); if (rst) return;
      if (rsp_valid === 1'b1) begin d = rsp_rdata; break; end
      n++;
      if (n == TO) begin exp_split = 1; m_split_cycle = n + 1; end
    end
    exp_split = 0; exp_svalid = 1;
    for (int i = 0; i < DW; i++) begin
      exp_rd = d[DW-1];
      do begin m_step(rst); if (rst) return; end while (master_ready !== 1'b1);
      m_bits.push_back(d[DW-1]);
      d = d << 1;
    end
  endtask

  initial begin : model
    m_split_cycle = 0;
    forever begin
      m_clear();
      if (rstn !== 1'b1) @(posedge rstn);
      m_txn();
    end
  end

  // Checking and stimulus share one process
  int n_tests, n_fail, rv_total;
  bit dut_bits[$];
  logic [AW-1:0] dut_last_addr;
  logic [DW-1:0] dut_last_wdata;
  logic dut_last_wr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_slave_ready", 32'(bus_a.slave_ready), 32'(exp_sready));
    chk("a_slave_valid", 32'(bus_a.slave_valid), 32'(exp_svalid));
    chk("a_split", 32'(bus_a.split), 32'(exp_split));
    chk("a_req_valid", 32'(bus_a.req_valid), 32'(exp_rv));
    chk("a_rd_bus", 32'(bus_a.rd_bus), 32'(exp_rd));
    chk("b_slave_ready", 32'(bus_b.slave_ready), 32'(exp_sready));
    chk("b_slave_valid", 32'(bus_b.slave_valid), 32'(exp_svalid));
    chk("b_split", 32'(bus_b.split), 32'd0);
    chk("b_req_valid", 32'(bus_b.req_valid), 32'(exp_rv));
    chk("b_rd_bus", 32'(bus_b.rd_bus), 32'(exp_rd));
    if (exp_rv) begin
      chk("a_req_write", 32'(bus_a.req_write), 32'(exp_wr));
      chk("a_req_addr", 32'(bus_a.req_addr), 32'(exp_addr));
      chk("a_req_wdata", 32'(bus_a.req_wdata), 32'(exp_wdata));
      chk("b_req_addr", 32'(bus_b.req_addr), 32'(exp_addr));
      chk("b_req_wdata", 32'(bus_b.req_wdata), 32'(exp_wdata));
    end
    if (bus_a.req_valid === 1'b1) rv_total++;
    if (bus_a.req_valid === 1'b1 && req_ready === 1'b1) begin
      dut_last_addr = bus_a.req_addr; dut_last_wdata = bus_a.req_wdata; dut_last_wr = bus_a.req_write;
    end
    if (bus_a.slave_valid === 1'b1 && master_ready === 1'b1) dut_bits.push_back(bus_a.rd_bus);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    if (rand_en) begin
      req_ready    = ($urandom_range(0, 2) != 0);
      master_ready = 1'($urandom_range(0, 1));
      rsp_valid    = ($urandom_range(0, 5) == 0);
      rsp_rdata    = DW'($urandom);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (m_idle !== 1'b1 && k < budget) begin tick(); k++; end
    chk("idle_within_budget", 32'(m_idle), 32'd1);
  endtask

  task automatic send_bits(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stop_after);
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    sa = a; sd = d;
    master_valid = 1; mode = w; wr_bus = 0;
    tick();
    for (int i = 0; i < AW; i++) begin
      if (i == stop_after) begin master_valid = 0; tick(); return; end
      wr_bus = sa[AW-1]; sa = sa << 1;
      tick();
    end
    if (w) begin
      for (int i = 0; i < DW; i++) begin wr_bus = sd[DW-1]; sd = sd << 1; tick(); end
    end
    master_valid = 0; wr_bus = 0;
  endtask

  task automatic check_bits(input string name, input int db0, input int mb0, input logic [DW-1:0] want);
    logic [DW-1:0] w;
    w = want;
    chk({name, "_dut_bit_count"}, 32'(dut_bits.size() - db0), 32'(DW));
    chk({name, "_model_bit_count"}, 32'(m_bits.size() - mb0), 32'(DW));
    for (int i = 0; i < DW; i++) begin
      if (db0 + i < dut_bits.size()) chk({name, "_dut_bit"}, 32'(dut_bits[db0 + i]), 32'(w[DW-1]));
      if (mb0 + i < m_bits.size()) chk({name, "_model_bit"}, 32'(m_bits[mb0 + i]), 32'(w[DW-1]));
      w = w << 1;
    end
  endtask

  initial begin : main
    int rv0, b0, mb0, first_split, stop;
    logic split_c10;
    bit w;
    rstn = 0; mode = 0; wr_bus = 0; master_valid = 0; master_ready = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rand_en = 0;
    repeat (3) tick();
    chk("rst_req_valid", 32'(bus_a.req_valid), 32'd0);
    chk("rst_req_addr", 32'(bus_a.req_addr), 32'd0);
    chk("rst_req_wdata", 32'(bus_a.req_wdata), 32'd0);
    rstn = 1;
    repeat (2) tick();

    // Write, request accepted at once
    req_ready = 1; master_ready = 1; rv0 = rv_total;
    send_bits(1, 16'h1234, 8'hA5, -1);
    wait_idle(20);
    chk("t1_req_pulses", 32'(rv_total - rv0), 32'd1);
    chk("t1_model_addr", 32'(m_last_addr), 32'h1234);
    chk("t1_model_wdata", 32'(m_last_wdata), 32'hA5);
    chk("t1_dut_addr", 32'(dut_last_addr), 32'h1234);
    chk("t1_dut_wdata", 32'(dut_last_wdata), 32'hA5);
    chk("t1_dut_write", 32'(dut_last_wr), 32'd1);

    // Write held off by req_ready for 5 cycles
    req_ready = 0; rv0 = rv_total;
    send_bits(1, 16'h5AC3, 8'h3E, -1);
    repeat (5) tick();
    req_ready = 1;
    tick();
    wait_idle(20);
    chk("t2_req_valid_cycles", 32'(rv_total - rv0), 32'd6);

    // Read with a late response and a stuttering master
    master_ready = 0; b0 = dut_bits.size(); mb0 = m_bits.size();
    send_bits(0, 16'h00FF, 8'h00, -1);
    tick(); tick(); tick();
    rsp_valid = 1; rsp_rdata = 8'h3C;
    tick();
    rsp_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_idle) break;
      master_ready = ~master_ready;
      tick();
    end
    wait_idle(20);
    check_bits("t3", b0, mb0, 8'h3C);

    // Split after the timeout, response after 10 wait cycles
    master_ready = 1; b0 = dut_bits.size(); mb0 = m_bits.size();
    send_bits(0, 16'h0ABC, 8'h00, -1);
    tick();
    first_split = 0; split_c10 = 0;
    for (int k = 1; k <= 11; k++) begin
      if (bus_a.split === 1'b1 && first_split == 0) first_split = k;
      if (k == 10) split_c10 = bus_a.split;
      if (k == 11) begin rsp_valid = 1; rsp_rdata = 8'h96; end
      tick();
    end
    rsp_valid = 0;
    wait_idle(40);
    chk("t4_split_first_cycle", 32'(first_split), 32'd5);
    chk("t4_model_split_cycle", 32'(m_split_cycle), 32'd5);
    chk("t4_split_held", 32'(split_c10), 32'd1);
    check_bits("t4", b0, mb0, 8'h96);

    // Abort after 7 address bits, then a clean write
    rv0 = rv_total;
    send_bits(1, 16'hFFFF, 8'h11, 7);
    repeat (4) tick();
    chk("t5_no_request", 32'(rv_total - rv0), 32'd0);
    send_bits(1, 16'hBEEF, 8'h5A, -1);
    wait_idle(20);
    chk("t5_dut_addr", 32'(dut_last_addr), 32'hBEEF);
    chk("t5_dut_wdata", 32'(dut_last_wdata), 32'h5A);

    // Asynchronous reset mid-SEND and mid-REQ
    master_ready = 0;
    send_bits(0, 16'h0F0F, 8'h00, -1);
    tick();
    rsp_valid = 1; rsp_rdata = 8'hFF;
    tick();
    rsp_valid = 0;
    tick();
    chk("t6_in_send", 32'(bus_a.slave_valid), 32'd1);
    rstn = 0;
    #1;
    chk("t6_send_svalid_async", 32'(bus_a.slave_valid), 32'd0);
    chk("t6_send_rd_bus_async", 32'(bus_a.rd_bus), 32'd0);
    repeat (2) tick();
    rstn = 1;
    tick();
    req_ready = 0;
    send_bits(1, 16'h2222, 8'h33, -1);
    tick();
    chk("t6_in_req", 32'(bus_a.req_valid), 32'd1);
    rstn = 0;
    #1;
    chk("t6_req_valid_async", 32'(bus_a.req_valid), 32'd0);
    chk("t6_req_addr_async", 32'(bus_a.req_addr), 32'd0);
    repeat (2) tick();
    rstn = 1;
    rsp_valid = 1; rsp_rdata = 8'hAA;
    repeat (3) tick();
    rsp_valid = 0;
    chk("t6_rsp_in_idle_ignored", 32'(bus_a.slave_valid), 32'd0);

    // Randomized traffic
    rand_en = 1;
    for (int t = 0; t < 60; t++) begin
      wait_idle(400);
      w = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, AW - 1)) : -1;
      send_bits(w, AW'($urandom), DW'($urandom), stop);
    end
    wait_idle(400);
    rand_en = 0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
